// File: rtl/conv_pkg.sv
// Shared constants, FSM encoding and byte-lane helpers for the conv front end.
// Packing orders are defined once here so the loader and the array agree.
package conv_pkg;
    localparam int PIX_W       = 8;
    localparam int N_PIX       = 25;
    localparam int N_WGT       = 9;
    localparam int HOLD_CYCLES = 4;
    localparam int HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    // Pixels fill from the LSB lane up; weight 0 lands in the MSB lane.
    localparam bit F_MSB_FIRST = 1'b0;
    localparam bit W_MSB_FIRST = 1'b1;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        PRESENT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    function automatic int lane_of(
        input int n,
        input int idx,
        input bit msb_first
    );
        return msb_first ? (n - 1 - idx) : idx;
    endfunction
endpackage

// File: rtl/conv_byte_packer.sv
// N-byte register file written one lane per accepted byte.
// WRAP=1: index wraps at N and sets a sticky done flag; WRAP=0: saturates at N.
module conv_byte_packer
    import conv_pkg::*;
#(
    parameter int N         = 9,
    parameter int W         = 8,
    parameter bit WRAP      = 1'b0,
    parameter bit MSB_FIRST = 1'b0,
    parameter int CW        = $clog2(N + 1)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clr,
    input  logic           i_we,
    input  logic [W-1:0]   i_data,
    output logic [N*W-1:0] o_vec,
    output logic           o_done
);
    logic [N*W-1:0] r_vec;
    logic [CW-1:0]  r_cnt;
    logic           r_wrapped;
    int             w_lane;

    always_comb w_lane = lane_of(N, int'(r_cnt), MSB_FIRST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vec     <= '0;
            r_cnt     <= '0;
            r_wrapped <= 1'b0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_we && (r_cnt < CW'(N))) begin
            r_vec[w_lane*W +: W] <= i_data;
            if (WRAP && (r_cnt == CW'(N - 1))) begin
                r_cnt     <= '0;
                r_wrapped <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_vec  = r_vec;
    assign o_done = WRAP ? r_wrapped : (r_cnt == CW'(N));
endmodule

// File: rtl/conv_frame_loader.sv
// Byte-stream loader packing a 5x5 frame and 3x3 kernel for the MAC array.
// Optional CONV_FRAME_CNT_EN adds a 16-bit accepted-frame counter output.
module conv_frame_loader
    import conv_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PIX_W-1:0]       s_data,
    input  logic                   s_sel,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic [N_PIX*PIX_W-1:0] m_f,
    output logic [N_WGT*PIX_W-1:0] m_w,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic                   m_busy
`ifdef CONV_FRAME_CNT_EN
    ,
    output logic [15:0]            frame_cnt
`endif
);
    state_t            r_state;
    logic [HOLD_W-1:0] r_hold;
    logic              r_valid;
    logic              r_busy;
    logic              w_pix_full;
    logic              w_w_loaded;
    logic              w_acc;
    logic              w_clr;

    // With pixels complete, only weights still missing may enter.
    assign s_ready = rst_n && (r_state == FILL) &&
                     (!w_pix_full || (s_sel && !w_w_loaded));
    assign w_acc   = s_valid && s_ready;
    assign w_clr   = (r_state == HOLD) && (r_hold == '0);

    conv_byte_packer #(
        .N(N_PIX), .W(PIX_W), .WRAP(1'b0), .MSB_FIRST(F_MSB_FIRST)
    ) u_pix (
        .clk(clk), .rst_n(rst_n), .i_clr(w_clr),
        .i_we(w_acc && !s_sel), .i_data(s_data),
        .o_vec(m_f), .o_done(w_pix_full)
    );

    conv_byte_packer #(
        .N(N_WGT), .W(PIX_W), .WRAP(1'b1), .MSB_FIRST(W_MSB_FIRST)
    ) u_wgt (
        .clk(clk), .rst_n(rst_n), .i_clr(1'b0),
        .i_we(w_acc && s_sel), .i_data(s_data),
        .o_vec(m_w), .o_done(w_w_loaded)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_hold  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_pix_full && w_w_loaded) begin
                        r_state <= PRESENT;
                        r_valid <= 1'b1;
                    end
                end
                PRESENT: begin
                    if (m_ready) begin
                        r_state <= HOLD;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_hold  <= HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
                HOLD: begin
                    if (r_hold == '0) begin
                        r_state <= FILL;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold <= r_hold - 1'b1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign m_valid = r_valid;
    assign m_busy  = r_busy;

`ifdef CONV_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_frame_cnt <= '0;
        else if (r_valid && m_ready)
            r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`endif
endmodule

// File: tb/tb_conv_frame_loader.sv
// Directed scoreboard bench for conv_frame_loader.
// Expected frames are queued as bytes are driven and popped at m_valid.
module tb_conv_frame_loader;
    typedef struct {
        logic [199:0] f;
        logic [71:0]  w;
    } frame_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   s_data;
    logic         s_sel;
    logic         s_valid;
    logic         s_ready;
    logic [199:0] m_f;
    logic [71:0]  m_w;
    logic         m_valid;
    logic         m_ready;
    logic         m_busy;
`ifdef CONV_FRAME_CNT_EN
    logic [15:0]  frame_cnt;
`endif

    int     total = 0;
    int     bad   = 0;
    frame_t sb[$];

    conv_frame_loader dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_sel(s_sel),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_f(m_f), .m_w(m_w),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_busy(m_busy)
`ifdef CONV_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [199:0] obs,
                       input logic [199:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until the DUT takes it.
    task automatic send(input logic sel, input logic [7:0] d);
        int n;
        n = 0;
        s_sel = sel;
        s_data = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            bad++;
            $error("FAIL accept_timeout got=%0d want=<100", n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag,
                              output int cyc,
                              output frame_t e);
        int n;
        n = 0;
        e.f = '0;
        e.w = '0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_valid && n < 200);
        cyc = n;
        chki({tag, "_valid"}, int'(m_valid), 1);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s_sb got=empty want=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_f"}, m_f, e.f);
            chk({tag, "_w"}, {128'h0, m_w}, {128'h0, e.w});
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t e;
        frame_t last;
        int     cyc;
        int     nb;
        int     nv;
        int     nr;
        int     nc;
        logic [71:0] w2;

        rst_n = 1'b0;
        s_data = '0;
        s_sel = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_f", m_f, '0);
        chk("rst_w", {128'h0, m_w}, '0);
        chki("rst_valid", int'(m_valid), 0);
        chki("rst_busy", int'(m_busy), 0);
        chki("rst_ready", int'(s_ready), 0);
        rst_n = 1'b1;

        // weights first, then pixels, downstream always ready
        m_ready = 1'b1;
        for (int k = 0; k < 9; k++) send(1'b1, 8'(k + 1));
        for (int k = 0; k < 25; k++) begin
            send(1'b0, 8'(k + 1));
            e.f[8*k +: 8] = 8'(k + 1);
        end
        e.w = 72'h010203040506070809;
        sb.push_back(e);
        chki("t1_early", int'(m_valid), 0);
        wait_frame("t1", cyc, last);
        chki("t1_lat", cyc, 1);
        chk("t1_f0", {192'h0, m_f[7:0]}, 200'h01);
        chk("t1_f24", {192'h0, m_f[199:192]}, 200'h19);
        nb = 0;
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            nb += int'(m_busy);
            nv += int'(m_valid);
        end
        chki("t1_busy_len", nb, 4);
        chki("t1_valid_len", nv, 0);
        s_sel = 1'b0;
        #1;
        chki("t1_ready_back", int'(s_ready), 1);

        // pixels before any weights: extra pixels must be refused
        do_reset();
        m_ready = 1'b0;
        for (int k = 0; k < 25; k++) begin
            send(1'b0, 8'(8'h20 + k));
            e.f[8*k +: 8] = 8'(8'h20 + k);
        end
        s_sel = 1'b0;
        s_data = 8'h99;
        s_valid = 1'b1;
        nr = 0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nr += int'(s_ready);
            nv += int'(m_valid);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chki("t2_pix_refused", nr, 0);
        chki("t2_no_valid", nv, 0);
        for (int k = 0; k < 9; k++) begin
            send(1'b1, 8'(8'h80 + 7 * k));
            w2[8*(8-k) +: 8] = 8'(8'h80 + 7 * k);
        end
        e.w = w2;
        sb.push_back(e);
        chki("t2_early", int'(m_valid), 0);
        wait_frame("t2", cyc, last);
        chki("t2_lat", cyc, 1);

        // backpressure with a pixel byte pending
        s_sel = 1'b0;
        s_data = 8'h55;
        s_valid = 1'b1;
        nv = 0;
        nr = 0;
        nc = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            nv += int'(!m_valid);
            nr += int'(s_ready);
            nc += int'((m_f !== last.f) || (m_w !== last.w));
        end
        chki("t3_valid_drop", nv, 0);
        chki("t3_ready", nr, 0);
        chki("t3_changed", nc, 0);
        s_valid = 1'b0;
        m_ready = 1'b1;

        // second frame reuses the kernel
        for (int k = 0; k < 25; k++) send(1'b0, 8'hFF);
        e.f = {200{1'b1}};
        e.w = w2;
        sb.push_back(e);
        wait_frame("t4", cyc, last);

        // async reset in the middle of a fill
        for (int k = 0; k < 5; k++) send(1'b1, 8'(8'h11 * (k + 1)));
        for (int k = 0; k < 12; k++) send(1'b0, 8'(8'h40 + k));
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_f", m_f, '0);
        chk("t5_w", {128'h0, m_w}, '0);
        chki("t5_valid", int'(m_valid), 0);
        chki("t5_busy", int'(m_busy), 0);
        chki("t5_ready", int'(s_ready), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 25; k++) begin
            send(1'b0, 8'(8'h60 + k));
            e.f[8*k +: 8] = 8'(8'h60 + k);
        end
        s_sel = 1'b0;
        s_data = 8'h77;
        s_valid = 1'b1;
        nr = 0;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nr += int'(s_ready);
            nv += int'(m_valid);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        chki("t5_pix_refused", nr, 0);
        chki("t5_no_valid", nv, 0);
        for (int k = 0; k < 9; k++) begin
            send(1'b1, 8'(8'hC0 + k));
            e.w[8*(8-k) +: 8] = 8'(8'hC0 + k);
        end
        w2 = e.w;
        sb.push_back(e);
        wait_frame("t5", cyc, last);
        chki("t5_lat", cyc, 1);

`ifdef CONV_FRAME_CNT_EN
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < 25; k++) begin
                send(1'b0, 8'(j * 16 + k));
                e.f[8*k +: 8] = 8'(j * 16 + k);
            end
            e.w = w2;
            sb.push_back(e);
            wait_frame("t6", cyc, last);
        end
        @(posedge clk);
        #1;
        chk("t6_cnt3", {184'h0, frame_cnt}, 200'd3);
        force dut.r_frame_cnt = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.r_frame_cnt;
        for (int k = 0; k < 25; k++) send(1'b0, 8'h33);
        e.f = {25{8'h33}};
        e.w = w2;
        sb.push_back(e);
        wait_frame("t6w", cyc, last);
        @(posedge clk);
        #1;
        chk("t6_wrap", {184'h0, frame_cnt}, 200'd0);
`endif

        chki("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv_frame_loader.md
Name: conv_frame_loader

Overview:
- Front end that produces the operands for the 3x3/5x5 convolution array.
- Accepts a byte stream of pixels and weights over a valid/ready handshake.
- Packs 25 pixels into a 200-bit feature vector and 9 weights into a 72-bit kernel vector.
- Presents both, stable, to the downstream MAC array for a fixed accumulation window, then refills.

Parameters:
- PIX_W, 8, bits per pixel and per weight.
- N_PIX, 25, pixels per frame (5x5, row-major).
- N_WGT, 9, weights per kernel (3x3, row-major).
- HOLD_CYCLES, 4, cycles that outputs stay frozen after handshake; covers the MAC 4-phase count.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  PIX_W  input byte.
- s_sel  in  1  0 = pixel byte, 1 = weight byte.
- s_valid  in  1  input byte valid.
- s_ready  out  1  loader can accept a byte.
- m_f  out  N_PIX*PIX_W  pixel k at bits [8k+7:8k].
- m_w  out  N_WGT*PIX_W  weight k at bits [71-8k:64-8k], so weight 0 is the MSB byte.
- m_valid  out  1  frame and kernel complete and presented.
- m_ready  in  1  downstream accepts the presented frame.
- m_busy  out  1  high during HOLD.

Behaviour:
- Reset (async, rst_n low):
  - state = FILL, pix_cnt = 0, wgt_cnt = 0, w_loaded = 0, hold_cnt = 0.
  - m_f = 0, m_w = 0, m_valid = 0, m_busy = 0, s_ready = 0 while in reset.
- Handshake:
  - A byte is accepted on a cycle where s_valid && s_ready.
  - s_ready is a registered-state decode: 1 in FILL, 0 in PRESENT and HOLD.
- FILL:
  - Pixel accept: write m_f byte pix_cnt; pix_cnt++.
  - Weight accept: write m_w byte wgt_cnt. At wgt_cnt == 8, wrap to 0 and set w_loaded = 1; otherwise wgt_cnt++.
  - A new weight set overwrites the old one in place; w_loaded stays 1.
  - When pix_cnt reaches 25 and w_loaded = 1, go to PRESENT on the next edge.
  - If pix_cnt == 25 and w_loaded = 0:
    - Stay in FILL.
    - Further pixel bytes are not accepted; s_ready = s_sel, so only weights are taken.
    - Enter PRESENT the cycle after the 9th weight is accepted.
- PRESENT:
  - m_valid = 1; m_f and m_w are frozen.
  - On m_ready: m_valid drops next cycle, hold_cnt = HOLD_CYCLES-1, go to HOLD.
  - m_valid never drops without m_ready.
- HOLD:
  - m_busy = 1, outputs frozen, hold_cnt decrements.
  - At hold_cnt == 0: go to FILL with pix_cnt = 0. m_f is not cleared and is overwritten byte by byte.
  - Weights persist across frames.
- Latency: the 25th pixel (or final weight) accepted at edge N gives m_valid = 1 after edge N+1.
- Reset mid-operation: immediate return to the reset state. A partial frame and partial weights are discarded, and w_loaded is cleared.
- Counters: pix_cnt is 5 bits and saturates at 25; wgt_cnt is 4 bits and wraps at 9; hold_cnt is clog2(HOLD_CYCLES) bits.
- No arithmetic on data; bytes are passed bit-exact (signed interpretation is downstream).

Optional Feature:
- Macro: CONV_FRAME_CNT_EN.
- When defined:
  - Extra output frame_cnt, out, 16 bits.
  - Increments on each m_valid && m_ready and wraps 0xFFFF -> 0.
  - Reset value 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package conv_pkg holds:
  - PIX_W, N_PIX, N_WGT, and HOLD_CYCLES.
  - State encoding: FILL = 2'd0, PRESENT = 2'd1, HOLD = 2'd2.
  - Byte-lane index helpers for the f/w packing, so the loader and the convolution array agree.
- One natural sub-module, conv_byte_packer: a parameterised N-byte register file with write-enable, index, and a wrap/complete flag. It is instantiated twice, once for the 25-byte pixel buffer and once for the 9-byte weight buffer.

Test Plan:
- Weights then pixels:
  - Stimulus: weights 1..9, then pixels 0x01..0x19, m_ready = 1.
  - Required: m_w = 0x010203040506070809; m_f[7:0] = 0x01; m_f[199:192] = 0x19.
  - Required: m_valid lasts 1 cycle; m_busy lasts 4 cycles; s_ready returns after that.
- Pixels before weights:
  - Stimulus: 25 pixels sent with no weights loaded, then one extra pixel byte.
  - Required: s_ready = 0 for pixels; m_valid stays 0.
  - Then 9 weights: m_valid = 1 the cycle after the 9th weight.
- Backpressure:
  - Stimulus: hold m_ready = 0 for 10 cycles in PRESENT while s_valid stays high.
  - Required: m_valid stays 1, m_f/m_w do not change, s_ready = 0, and no byte is accepted.
- Weight persistence:
  - Stimulus: a second frame of 25 pixels of value 0xFF with no new weights.
  - Required: m_w is unchanged; m_f is all 0xFF.
- Reset mid-fill:
  - Stimulus: assert rst_n = 0 asynchronously after 12 pixels and 5 weights.
  - Required: all outputs are 0 immediately; after release, 9 weights plus 25 pixels are needed to reach m_valid.
- CONV_FRAME_CNT_EN:
  - Stimulus: 3 frames accepted.
  - Required: frame_cnt = 3. Also preload 0xFFFF via 65535 frames or force, then one more frame: frame_cnt wraps to 0.
